inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Front end of the pipeline: generates the PC stream, issues in-order read requests to instruction
//  memory and buffers returned words in a small prefetch queue. Presents { INST_PC, INST_DATA } to
//  the decode stage, which consumes one entry per cycle when !STALL && !MEM_WAIT.
//  On FLUSH it redirects to NEW_PC and discards every in-flight response.
// PARAMETERS
//  START_ADDR  32'h0000_0000  PC loaded on reset
//  DEPTH       4              prefetch queue entries (power of 2, >=2); also max in-flight requests
// PORTS
//  CLK          in   1   clock, all state on posedge
//  RST          in   1   asynchronous, active-high reset
//  FLUSH        in   1   redirect: discard queue and in-flight reads, restart at NEW_PC
//  NEW_PC       in   32  redirect target, sampled when FLUSH=1
//  STALL        in   1   decode stage holding; head entry is not consumed
//  MEM_WAIT     out  1   queue empty; decode must not capture INST_*
//  INST_PC      out  32  PC of head entry
//  INST_DATA    out  32  instruction word of head entry
//  MEM_RDEN     out  1   read request valid
//  MEM_RADDR    out  32  read address (word aligned)
//  MEM_RREADY   in   1   memory accepts the request this cycle
//  MEM_RVALID   in   1   read data valid; one per accepted request, strictly in order, >=1 cycle later
//  MEM_RDATA    in   32  read data
// BEHAVIOUR
//  State: req_pc, rsp_pc (32b each); queue of DEPTH x {pc,data}; count (0..DEPTH);
//   inflight (0..DEPTH), live in-flight reads; drop (0..DEPTH), in-flight reads to discard.
//  Reset (async): req_pc=rsp_pc=START_ADDR; count=inflight=drop=0; MEM_RDEN=0; MEM_WAIT=1;
//   INST_PC=0; INST_DATA=32'h0000_0013 (NOP).
//  Request: MEM_RDEN = !FLUSH && (count+inflight+drop) < DEPTH; MEM_RADDR = req_pc.
//   Accept when MEM_RDEN && MEM_RREADY: req_pc += 4 (wraps mod 2^32), inflight += 1.
//   MEM_RADDR holds until accepted.
//  Response, MEM_RVALID=1:
//   - drop>0: data discarded, drop -= 1.
//   - else inflight>0: push {rsp_pc, MEM_RDATA}, rsp_pc += 4, inflight -= 1.
//   - else: protocol error, ignored, no state change.
//  Reservation makes push-on-full impossible; the bench checks this with an assertion.
//  Output: head entry is combinational from the queue (no added latency). Empty queue gives
//   MEM_WAIT=1, INST_PC=0, INST_DATA=NOP.
//  Pop when count>0 && !STALL && !FLUSH. Push and pop in the same cycle leave count unchanged.
//  Min latency: request accepted cycle N, RVALID N+1, INST_* valid from N+2 (registered push).
//  FLUSH (overrides everything else in that cycle):
//   - queue cleared (count=0); req_pc=rsp_pc=NEW_PC; MEM_RDEN=0 during the FLUSH cycle.
//   - drop_next = drop + inflight - (RVALID ? 1 : 0), floored at 0; inflight=0.
//   - The request accepted this cycle is impossible (RDEN=0).
//   - Requests to NEW_PC start the next cycle, even while drop>0 (in-order return keeps this safe).
//   - Back-to-back FLUSH cycles accumulate drop correctly; the last NEW_PC wins.
//  STALL never blocks requests; prefetch continues until the queue plus reservations are full.
//  RST mid-burst: all in-flight data is forgotten. The memory must also be reset, otherwise a
//   stale RVALID is ignored per the protocol-error rule.
// TESTING
//  1 Reset, RREADY=1, RVALID 1-cycle echo of mem[a]=a^32'hA5A5_0000 -> first INST_PC=0 at cycle 2;
//    then PC 0,4,8,... one per cycle, MEM_WAIT=0 steady.
//  2 STALL=1 for 10 cycles -> exactly DEPTH requests outstanding/queued, MEM_RDEN=0,
//    INST_PC frozen; release -> PCs continue with no gap or duplicate.
//  3 Memory latency 3 cycles, 3 reads in flight, FLUSH NEW_PC=32'h100 -> 3 responses dropped,
//    next INST_PC=32'h100, no stale word ever visible.
//  4 FLUSH in the same cycle as an RVALID, then FLUSH again next cycle (NEW_PC=0x200) ->
//    drop counts exact, first output PC=0x200.
//  5 RREADY random 50% toggling, latency 1-4 -> output PC strictly +4 sequential; data matches mem.
//  6 Async RST asserted mid-cycle with queue full -> MEM_WAIT=1, INST_DATA=0x13 immediately;
//    restart at START_ADDR.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch front end: PC generator, in-order memory read requests, DEPTH-entry prefetch queue.
// Latency: request accepted cycle N, response N+1 or later, head entry visible the cycle after the response.
// Backpressure: STALL holds the head; requests stop once queued + in-flight + to-be-dropped reaches DEPTH.
module inst_fetch #(
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic [31:0] NEW_PC,
  input  logic        STALL,
  output logic        MEM_WAIT,
  output logic [31:0] INST_PC,
  output logic [31:0] INST_DATA,
  output logic        MEM_RDEN,
  output logic [31:0] MEM_RADDR,
  input  logic        MEM_RREADY,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 2;
  localparam logic [31:0]   NOP   = 32'h0000_0013;
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [AW-1:0] ONE_P = AW'(1);

  logic [31:0]   req_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   q_pc  [DEPTH];
  logic [31:0]   q_dat [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] inflight_nxt;
  logic [CW-1:0] drop_nxt;
  logic [SW-1:0] reserved;
  logic [SW-1:0] flush_drop;
  logic          accept;
  logic          push;
  logic          pop;

  // Every slot is claimed at request time, so a returning word always has room.
  assign reserved  = SW'(count) + SW'(inflight) + SW'(drop);
  assign MEM_RDEN  = !RST && !FLUSH && (reserved < SW'(DEPTH));
  assign MEM_RADDR = req_pc;
  assign accept    = MEM_RDEN && MEM_RREADY;
  assign push      = MEM_RVALID && !FLUSH && (drop == '0) && (inflight != '0);
  assign pop       = (count != '0) && !STALL && !FLUSH;

  assign MEM_WAIT  = (count == '0);
  assign INST_PC   = MEM_WAIT ? 32'h0 : q_pc[rd_ptr];
  assign INST_DATA = MEM_WAIT ? NOP   : q_dat[rd_ptr];

  // Live reads become discards on redirect; a response arriving in the same cycle retires one of them.
  always_comb begin
    flush_drop = SW'(drop) + SW'(inflight);
    if (MEM_RVALID && (flush_drop != '0))
      flush_drop = flush_drop - SW'(1);
  end

  always_comb begin
    count_nxt    = count;
    inflight_nxt = inflight;
    drop_nxt     = drop;
    if (FLUSH) begin
      count_nxt    = '0;
      inflight_nxt = '0;
      drop_nxt     = CW'(flush_drop);
    end else begin
      if (push && !pop)
        count_nxt = count + ONE_C;
      else if (!push && pop)
        count_nxt = count - ONE_C;
      if (accept && !push)
        inflight_nxt = inflight + ONE_C;
      else if (!accept && push)
        inflight_nxt = inflight - ONE_C;
      if (MEM_RVALID && (drop != '0))
        drop_nxt = drop - ONE_C;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      req_pc   <= START_ADDR;
      rsp_pc   <= START_ADDR;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      count    <= count_nxt;
      inflight <= inflight_nxt;
      drop     <= drop_nxt;
      if (FLUSH) begin
        req_pc <= NEW_PC;
        rsp_pc <= NEW_PC;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (accept)
          req_pc <= req_pc + 32'd4;
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
          wr_ptr <= wr_ptr + ONE_P;
        end
        if (pop)
          rd_ptr <= rd_ptr + ONE_P;
      end
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge CLK) begin
    if (push) begin
      q_pc[wr_ptr]  <= rsp_pc;
      q_dat[wr_ptr] <= MEM_RDATA;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: queue-based memory model with random latency/ready and an expected-PC stream model.
module tb_inst_fetch;
  localparam int          DEPTH = 4;
  localparam logic [31:0] START = 32'h0000_0000;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        FLUSH = 1'b0;
  logic [31:0] NEW_PC = '0;
  logic        STALL = 1'b0;
  logic        MEM_WAIT;
  logic [31:0] INST_PC;
  logic [31:0] INST_DATA;
  logic        MEM_RDEN;
  logic [31:0] MEM_RADDR;
  logic        MEM_RREADY = 1'b0;
  logic        MEM_RVALID = 1'b0;
  logic [31:0] MEM_RDATA = '0;

  int passed = 0;
  int total = 0;
  int lat_min = 1;
  int lat_max = 1;
  int rdy_pct = 100;
  int cyc = 0;
  int n_acc = 0;
  int consumed = 0;
  logic [31:0] exp_pc = START;

  typedef struct { logic [31:0] addr; int due; } rd_t;
  rd_t mq[$];

  inst_fetch #(.START_ADDR(START), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .NEW_PC(NEW_PC), .STALL(STALL),
    .MEM_WAIT(MEM_WAIT), .INST_PC(INST_PC), .INST_DATA(INST_DATA),
    .MEM_RDEN(MEM_RDEN), .MEM_RADDR(MEM_RADDR), .MEM_RREADY(MEM_RREADY),
    .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  // Memory: accepted reads queue up in order, each returns mem[a] = a ^ KEY after its latency.
  always @(posedge CLK) begin
    if (RST) begin
      mq.delete();
      n_acc = 0;
    end else begin
      if (MEM_RVALID && mq.size() > 0) void'(mq.pop_front());
      if (MEM_RDEN && MEM_RREADY) begin
        mq.push_back('{addr: MEM_RADDR, due: cyc + int'($urandom_range(lat_max, lat_min))});
        n_acc = n_acc + 1;
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge CLK) begin
    MEM_RREADY = (int'($urandom_range(99, 0)) < rdy_pct);
    if (!RST && mq.size() > 0 && mq[0].due <= cyc) begin
      MEM_RVALID = 1'b1;
      MEM_RDATA  = mq[0].addr ^ KEY;
    end else begin
      MEM_RVALID = 1'b0;
      MEM_RDATA  = 32'hDEAD_BEEF;
    end
  end

  always @(posedge CLK) begin
    if (!RST)
      assert (!(int'(dut.count) == DEPTH && dut.push && !dut.pop))
        else $error("FAIL push_on_full count=%0d", dut.count);
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic sample();
    @(negedge CLK);
    #1;
  endtask

  task automatic after_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; FLUSH = 1'b0; STALL = 1'b0;
    rdy_pct = 100; lat_min = 1; lat_max = 1;
    repeat (3) @(posedge CLK);
    sample();
    total++;
    if ({MEM_WAIT, MEM_RDEN, INST_PC, INST_DATA} !== {1'b1, 1'b0, 32'h0, NOP})
      $display("FAIL reset_outputs wait=%b rden=%b pc=%h data=%h want 1 0 00000000 %h",
               MEM_WAIT, MEM_RDEN, INST_PC, INST_DATA, NOP);
    else passed++;
    total++;
    if (MEM_RADDR !== START) $display("FAIL reset_raddr got %h want %h", MEM_RADDR, START);
    else passed++;
    after_edge();
    RST = 1'b0;
    exp_pc = START;
    consumed = 0;
    sample();
    total++;
    if (MEM_RDEN !== 1'b1 || MEM_WAIT !== 1'b1)
      $display("FAIL reset_cycle0 rden=%b wait=%b want 1 1", MEM_RDEN, MEM_WAIT);
    else passed++;
    sample();
    total++;
    if (MEM_WAIT !== 1'b1) $display("FAIL reset_cycle1 wait=%b want 1", MEM_WAIT);
    else passed++;
    sample();
    total++;
    if (MEM_WAIT !== 1'b0 || INST_PC !== START || INST_DATA !== (START ^ KEY))
      $display("FAIL reset_cycle2 wait=%b pc=%h data=%h want 0 %h %h",
               MEM_WAIT, INST_PC, INST_DATA, START, START ^ KEY);
    else passed++;
    exp_pc = exp_pc + 32'd4;
    consumed++;
  endtask

  task automatic test_sequential();
    repeat (20) begin
      sample();
      total++;
      if (MEM_WAIT !== 1'b0 || INST_PC !== exp_pc || INST_DATA !== (exp_pc ^ KEY))
        $display("FAIL seq_stream wait=%b pc=%h data=%h want 0 %h %h",
                 MEM_WAIT, INST_PC, INST_DATA, exp_pc, exp_pc ^ KEY);
      else passed++;
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
  endtask

  task automatic test_stall();
    after_edge();
    STALL = 1'b1;
    repeat (10) begin
      sample();
      total++;
      if (MEM_WAIT === 1'b0 && (INST_PC !== exp_pc || INST_DATA !== (exp_pc ^ KEY)))
        $display("FAIL stall_frozen pc=%h data=%h want %h %h", INST_PC, INST_DATA, exp_pc, exp_pc ^ KEY);
      else passed++;
    end
    total++;
    if (MEM_RDEN !== 1'b0 || MEM_WAIT !== 1'b0)
      $display("FAIL stall_full rden=%b wait=%b want 0 0", MEM_RDEN, MEM_WAIT);
    else passed++;
    total++;
    if (n_acc - consumed != DEPTH)
      $display("FAIL stall_outstanding got %0d want %0d", n_acc - consumed, DEPTH);
    else passed++;
    after_edge();
    STALL = 1'b0;
    repeat (15) begin
      sample();
      total++;
      if (MEM_WAIT !== 1'b0 || INST_PC !== exp_pc || INST_DATA !== (exp_pc ^ KEY))
        $display("FAIL stall_release wait=%b pc=%h data=%h want 0 %h %h",
                 MEM_WAIT, INST_PC, INST_DATA, exp_pc, exp_pc ^ KEY);
      else passed++;
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
  endtask

  task automatic test_flush_inflight();
    bit seen = 0;
    lat_min = 3; lat_max = 3; rdy_pct = 100;
    repeat (10) begin
      sample();
      if (!MEM_WAIT) begin
        total++;
        if (INST_PC !== exp_pc || INST_DATA !== (exp_pc ^ KEY))
          $display("FAIL flush_pre pc=%h data=%h want %h %h", INST_PC, INST_DATA, exp_pc, exp_pc ^ KEY);
        else passed++;
        exp_pc = exp_pc + 32'd4;
      end
    end
    after_edge();
    FLUSH = 1'b1; NEW_PC = 32'h0000_0100;
    sample();
    total++;
    if (MEM_RDEN !== 1'b0) $display("FAIL flush_rden got %b want 0", MEM_RDEN);
    else passed++;
    after_edge();
    FLUSH = 1'b0;
    exp_pc = 32'h0000_0100;
    sample();
    total++;
    if (MEM_WAIT !== 1'b1) $display("FAIL flush_cleared wait=%b want 1", MEM_WAIT);
    else passed++;
    for (int k = 0; k < 30 && !seen; k++) begin
      if (!MEM_WAIT) begin
        seen = 1;
        total++;
        if (INST_PC !== exp_pc || INST_DATA !== (exp_pc ^ KEY))
          $display("FAIL flush_first pc=%h data=%h want %h %h", INST_PC, INST_DATA, exp_pc, exp_pc ^ KEY);
        else passed++;
        exp_pc = exp_pc + 32'd4;
      end else sample();
    end
    if (!seen) begin
      total++;
      $display("FAIL flush_first_timeout wait=%b want 0 within 30 cycles", MEM_WAIT);
    end
    repeat (12) begin
      sample();
      if (!MEM_WAIT) begin
        total++;
        if (INST_PC !== exp_pc || INST_DATA !== (exp_pc ^ KEY))
          $display("FAIL flush_stream pc=%h data=%h want %h %h", INST_PC, INST_DATA, exp_pc, exp_pc ^ KEY);
        else passed++;
        exp_pc = exp_pc + 32'd4;
      end
    end
  endtask

  task automatic test_double_flush();
    bit hit = 0;
    bit seen = 0;
    lat_min = 1; lat_max = 4; rdy_pct = 100;
    for (int k = 0; k < 30 && !hit; k++) begin
      sample();
      if (MEM_RVALID) begin
        hit = 1;
        FLUSH = 1'b1; NEW_PC = 32'h0000_0180;
      end else if (!MEM_WAIT) begin
        total++;
        if (INST_PC !== exp_pc || INST_DATA !== (exp_pc ^ KEY))
          $display("FAIL dflush_pre pc=%h data=%h want %h %h", INST_PC, INST_DATA, exp_pc, exp_pc ^ KEY);
        else passed++;
        exp_pc = exp_pc + 32'd4;
      end
    end
    total++;
    if (!hit) $display("FAIL dflush_no_rvalid rvalid=%b want 1 within 30 cycles", MEM_RVALID);
    else passed++;
    after_edge();
    NEW_PC = 32'h0000_0200;
    sample();
    total++;
    if (MEM_RDEN !== 1'b0 || MEM_WAIT !== 1'b1)
      $display("FAIL dflush_second rden=%b wait=%b want 0 1", MEM_RDEN, MEM_WAIT);
    else passed++;
    after_edge();
    FLUSH = 1'b0;
    exp_pc = 32'h0000_0200;
    for (int k = 0; k < 30 && !seen; k++) begin
      sample();
      if (!MEM_WAIT) begin
        seen = 1;
        total++;
        if (INST_PC !== exp_pc || INST_DATA !== (exp_pc ^ KEY))
          $display("FAIL dflush_first pc=%h data=%h want %h %h", INST_PC, INST_DATA, exp_pc, exp_pc ^ KEY);
        else passed++;
        exp_pc = exp_pc + 32'd4;
      end
    end
    if (!seen) begin
      total++;
      $display("FAIL dflush_first_timeout wait=%b want 0 within 30 cycles", MEM_WAIT);
    end
    repeat (12) begin
      sample();
      if (!MEM_WAIT) begin
        total++;
        if (INST_PC !== exp_pc || INST_DATA !== (exp_pc ^ KEY))
          $display("FAIL dflush_stream pc=%h data=%h want %h %h", INST_PC, INST_DATA, exp_pc, exp_pc ^ KEY);
        else passed++;
        exp_pc = exp_pc + 32'd4;
      end
    end
  endtask

  task automatic test_random();
    int n = 0;
    rdy_pct = 50; lat_min = 1; lat_max = 4;
    after_edge();
    // Start just below the top of the address space so the PC wraps.
    FLUSH = 1'b1; NEW_PC = 32'hFFFF_FFF8; STALL = 1'b0;
    for (int i = 0; i < 400; i++) begin
      sample();
      if (!MEM_WAIT && !STALL && !FLUSH) begin
        total++;
        if (INST_PC !== exp_pc || INST_DATA !== (exp_pc ^ KEY))
          $display("FAIL rand_stream pc=%h data=%h want %h %h", INST_PC, INST_DATA, exp_pc, exp_pc ^ KEY);
        else passed++;
        exp_pc = exp_pc + 32'd4;
        n++;
      end
      after_edge();
      if (FLUSH) exp_pc = NEW_PC;
      if (i < 399 && int'($urandom_range(99, 0)) < 4) begin
        FLUSH = 1'b1;
        NEW_PC = $urandom() & 32'hFFFF_FFFC;
      end else FLUSH = 1'b0;
      STALL = (i < 399) && (int'($urandom_range(99, 0)) < 30);
    end
    total++;
    if (n < 40) $display("FAIL rand_throughput consumed=%0d want >=40", n);
    else passed++;
  endtask

  task automatic test_reset_midburst();
    rdy_pct = 100; lat_min = 1; lat_max = 1;
    after_edge();
    STALL = 1'b1;
    repeat (8) sample();
    total++;
    if (MEM_WAIT !== 1'b0 || MEM_RDEN !== 1'b0)
      $display("FAIL midrst_full wait=%b rden=%b want 0 0", MEM_WAIT, MEM_RDEN);
    else passed++;
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    total++;
    if ({MEM_WAIT, MEM_RDEN, INST_PC, INST_DATA} !== {1'b1, 1'b0, 32'h0, NOP})
      $display("FAIL midrst_async wait=%b rden=%b pc=%h data=%h want 1 0 00000000 %h",
               MEM_WAIT, MEM_RDEN, INST_PC, INST_DATA, NOP);
    else passed++;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0; STALL = 1'b0;
    exp_pc = START;
    sample();
    total++;
    if (MEM_RDEN !== 1'b1 || MEM_WAIT !== 1'b1 || MEM_RADDR !== START)
      $display("FAIL midrst_restart rden=%b wait=%b raddr=%h want 1 1 %h", MEM_RDEN, MEM_WAIT, MEM_RADDR, START);
    else passed++;
    sample();
    sample();
    repeat (10) begin
      total++;
      if (MEM_WAIT !== 1'b0 || INST_PC !== exp_pc || INST_DATA !== (exp_pc ^ KEY))
        $display("FAIL midrst_stream wait=%b pc=%h data=%h want 0 %h %h",
                 MEM_WAIT, INST_PC, INST_DATA, exp_pc, exp_pc ^ KEY);
      else passed++;
      exp_pc = exp_pc + 32'd4;
      sample();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_flush_inflight();
    test_double_flush();
    test_random();
    test_reset_midburst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
